macc_sched: RTL and testbench

MACC_SCHED -- requirements
Module: macc_sched

---
 rtl/macc_sched.sv | 134 +++++++++++++
 tb/tb_macc_sched.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/macc_sched.sv
// macc_sched: round-robin scheduler sharing one hls_macc instance among NREQ requesters.
// Optional RUN-cycle timeout abort is compiled in when MACC_SCHED_TIMEOUT_EN is defined.
module macc_sched #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 15
) (
   input  logic            ap_clk,
   input  logic            ap_rst_n,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic            mac_ap_start,
   input  logic            mac_ap_done,
   input  logic [31:0]     mac_ap_return,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [1:0]      rsp_id,
   output logic [31:0]     rsp_data,
   output logic            rsp_err,
   output logic            busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_r;
   logic [NREQ-1:0] gnt_r;
   logic [1:0]      idx_r;
   logic [1:0]      ptr_r;
   logic [1:0]      rsp_id_r;
   logic [31:0]     rsp_data_r;
   logic [1:0]      pick_idx_s;
   logic            pick_found_s;
`ifdef MACC_SCHED_TIMEOUT_EN
   logic [3:0]      cnt_r;
   logic            rsp_err_r;
`endif

   // The 2-bit ID and 4-bit RUN counter only cover these parameter ranges.
   generate
      if (NREQ != 4 || TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_param
         $error("macc_sched: NREQ must be 4 and TIMEOUT must be in 1..15");
      end
   endgenerate

   // Round-robin pick: first asserted request at or above ptr, wrapping 3->0.
   always_comb begin
      pick_found_s = 1'b0;
      pick_idx_s   = ptr_r;
      for (int i = 0; i < NREQ; i++) begin
         if (!pick_found_s && req[2'(ptr_r + 2'(i))]) begin
            pick_found_s = 1'b1;
            pick_idx_s   = 2'(ptr_r + 2'(i));
         end else begin
            pick_found_s = pick_found_s;
         end
      end
   end

   // Scheduler FSM: grant, wait for done (or timeout), hold response until accepted.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_r    <= IDLE;
         gnt_r      <= {NREQ{1'b0}};
         idx_r      <= 2'd0;
         ptr_r      <= 2'd0;
         rsp_id_r   <= 2'd0;
         rsp_data_r <= 32'd0;
`ifdef MACC_SCHED_TIMEOUT_EN
         cnt_r      <= 4'd0;
         rsp_err_r  <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (pick_found_s) begin
                  gnt_r   <= {{(NREQ-1){1'b0}}, 1'b1} << pick_idx_s;
                  idx_r   <= pick_idx_s;
                  state_r <= RUN;
               end else begin
                  gnt_r   <= {NREQ{1'b0}};
               end
`ifdef MACC_SCHED_TIMEOUT_EN
               cnt_r <= 4'd0;
`endif
            end
            RUN: begin
               // done has priority over a timeout landing in the same cycle
               if (mac_ap_done) begin
                  rsp_data_r <= mac_ap_return;
                  rsp_id_r   <= idx_r;
                  state_r    <= RESP;
`ifdef MACC_SCHED_TIMEOUT_EN
                  rsp_err_r  <= 1'b0;
               end else if (cnt_r == 4'(TIMEOUT - 1)) begin
                  rsp_data_r <= 32'd0;
                  rsp_id_r   <= idx_r;
                  rsp_err_r  <= 1'b1;
                  state_r    <= RESP;
               end else begin
                  cnt_r      <= cnt_r + 4'd1;
`endif
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state_r <= IDLE;
                  gnt_r   <= {NREQ{1'b0}};
                  ptr_r   <= idx_r + 2'd1;
               end
            end
            default: begin
               state_r <= IDLE;
               gnt_r   <= {NREQ{1'b0}};
            end
         endcase
      end
   end

   assign gnt          = gnt_r;
   assign mac_ap_start = (state_r == RUN);
   assign rsp_valid    = (state_r == RESP);
   assign busy         = (state_r != IDLE);
   assign rsp_id       = rsp_id_r;
   assign rsp_data     = rsp_data_r;
`ifdef MACC_SCHED_TIMEOUT_EN
   assign rsp_err      = rsp_err_r;
`else
   assign rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_macc_sched.sv
// Directed self-checking bench for macc_sched with a small hls_macc stand-in
// (result in1*in2+7; 3-cycle latency when in1==in2, 5 otherwise).
module tb_macc_sched;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n = 1'b0;
   logic [3:0]  req = 4'd0;
   logic [3:0]  gnt;
   logic        mac_ap_start;
   logic        mac_ap_done;
   logic [31:0] mac_ap_return;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [1:0]  rsp_id;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [31:0] in1_a [4];
   logic [31:0] in2_a [4];
   logic [31:0] cur_in1, cur_in2;
   logic        m_active, m_done;
   logic [3:0]  m_cnt, m_lat;
   logic [31:0] m_ret;
   logic        stuck = 1'b0;
   logic        force_done = 1'b0;

   macc_sched #(.NREQ(4), .TIMEOUT(15)) dut (
      .ap_clk        (ap_clk),
      .ap_rst_n      (ap_rst_n),
      .req           (req),
      .gnt           (gnt),
      .mac_ap_start  (mac_ap_start),
      .mac_ap_done   (mac_ap_done),
      .mac_ap_return (mac_ap_return),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_id        (rsp_id),
      .rsp_data      (rsp_data),
      .rsp_err       (rsp_err),
      .busy          (busy)
   );

   always #5 ap_clk = ~ap_clk;

   assign mac_ap_done   = m_done | force_done;
   assign mac_ap_return = m_ret;

   // Operand mux selected by the one-hot grant.
   always_comb begin
      cur_in1 = 32'd0;
      cur_in2 = 32'd0;
      for (int i = 0; i < 4; i++) begin
         if (gnt[i]) begin
            cur_in1 = in1_a[i];
            cur_in2 = in2_a[i];
         end
      end
   end

   // hls_macc stand-in: done pulses lat edges after start is first seen.
   always @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         m_active <= 1'b0;
         m_done   <= 1'b0;
         m_cnt    <= 4'd0;
         m_lat    <= 4'd0;
         m_ret    <= 32'd0;
      end else if (m_done) begin
         m_done   <= 1'b0;
         m_active <= 1'b0;
      end else if (!m_active) begin
         if (mac_ap_start) begin
            m_active <= 1'b1;
            m_cnt    <= 4'd1;
            m_lat    <= (cur_in1 == cur_in2) ? 4'd3 : 4'd5;
            m_ret    <= cur_in1 * cur_in2 + 32'd7;
         end
      end else begin
         if (m_cnt != 4'hF) m_cnt <= m_cnt + 4'd1;
         if (!stuck && (int'(m_cnt) + 1 >= int'(m_lat))) m_done <= 1'b1;
      end
   end

   task automatic tick();
      @(negedge ap_clk);
   endtask

   task automatic test_reset();
      ap_rst_n = 1'b0; req = 4'd0; rsp_ready = 1'b0;
      repeat (2) tick();
      checks++;
      if ({gnt, mac_ap_start, rsp_valid, busy, rsp_err} !== 8'd0) begin
         errors++; $display("FAIL reset_ctrl: got %b expected %b", {gnt, mac_ap_start, rsp_valid, busy, rsp_err}, 8'd0);
      end
      checks++;
      if ({rsp_id, rsp_data} !== 34'd0) begin
         errors++; $display("FAIL reset_rsp: got %h expected %h", {rsp_id, rsp_data}, 34'd0);
      end
      ap_rst_n = 1'b1;
      tick();
      checks++;
      if ({gnt, busy} !== 5'd0) begin
         errors++; $display("FAIL reset_idle: got %b expected %b", {gnt, busy}, 5'd0);
      end
   endtask

   task automatic test_single();
      in1_a[0] = 32'd6; in2_a[0] = 32'd6;
      req = 4'b0001;
      tick();
      checks++;
      if ({gnt, busy, mac_ap_start} !== 6'b0001_11) begin
         errors++; $display("FAIL single_grant: got %b expected %b", {gnt, busy, mac_ap_start}, 6'b0001_11);
      end
      repeat (3) tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL single_early: got %b expected %b", rsp_valid, 1'b0);
      end
      tick();
      checks++;
      if ({rsp_valid, rsp_id, rsp_err, mac_ap_start} !== 5'b1_00_0_0) begin
         errors++; $display("FAIL single_rsp: got %b expected %b", {rsp_valid, rsp_id, rsp_err, mac_ap_start}, 5'b1_00_0_0);
      end
      checks++;
      if (rsp_data !== 32'd43) begin
         errors++; $display("FAIL single_data: got %0d expected %0d", rsp_data, 32'd43);
      end
      rsp_ready = 1'b1; req = 4'd0;
      tick();
      checks++;
      if ({rsp_valid, busy, gnt} !== 6'd0) begin
         errors++; $display("FAIL single_accept: got %b expected %b", {rsp_valid, busy, gnt}, 6'd0);
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_done_ignored();
      force_done = 1'b1;
      tick();
      force_done = 1'b0;
      tick();
      checks++;
      if ({busy, rsp_valid, gnt} !== 6'd0) begin
         errors++; $display("FAIL idle_done: got %b expected %b", {busy, rsp_valid, gnt}, 6'd0);
      end
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_d [4];
      int e;
      exp_d[0] = 32'd8; exp_d[1] = 32'd11; exp_d[2] = 32'd16; exp_d[3] = 32'd23;
      for (int i = 0; i < 4; i++) begin
         in1_a[i] = 32'(i + 1); in2_a[i] = 32'(i + 1);
      end
      ap_rst_n = 1'b0;
      tick();
      ap_rst_n = 1'b1; req = 4'hF; rsp_ready = 1'b1;
      tick();
      for (int n = 0; n < 5; n++) begin
         e = n % 4;
         checks++;
         if (gnt !== (4'b0001 << e)) begin
            errors++; $display("FAIL rr_grant%0d: got %b expected %b", n, gnt, 4'b0001 << e);
         end
         repeat (4) tick();
         checks++;
         if ({rsp_valid, rsp_id, rsp_err} !== {1'b1, 2'(e), 1'b0}) begin
            errors++; $display("FAIL rr_rsp%0d: got %b expected %b", n, {rsp_valid, rsp_id, rsp_err}, {1'b1, 2'(e), 1'b0});
         end
         checks++;
         if (rsp_data !== exp_d[e]) begin
            errors++; $display("FAIL rr_data%0d: got %0d expected %0d", n, rsp_data, exp_d[e]);
         end
         if (n == 4) req = 4'd0;
         tick();
         checks++;
         if ({gnt, busy} !== 5'd0) begin
            errors++; $display("FAIL rr_gap%0d: got %b expected %b", n, {gnt, busy}, 5'd0);
         end
         if (n < 4) tick();
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      in1_a[1] = 32'd5; in2_a[1] = 32'd7;
      req = 4'b0010; rsp_ready = 1'b0;
      tick();
      checks++;
      if (gnt !== 4'b0010) begin
         errors++; $display("FAIL bp_grant: got %b expected %b", gnt, 4'b0010);
      end
      repeat (5) tick();
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL bp_early: got %b expected %b", rsp_valid, 1'b0);
      end
      tick();
      for (int k = 0; k < 6; k++) begin
         checks++;
         if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {1'b1, 2'd1, 1'b0, 32'h0000_002A}) begin
            errors++; $display("FAIL bp_hold%0d: got %b/%0d/%h expected 1/1/2a", k, rsp_valid, rsp_id, rsp_data);
         end
         if (k < 5) tick();
      end
      rsp_ready = 1'b1; req = 4'd0;
      tick();
      checks++;
      if ({rsp_valid, busy} !== 2'b00) begin
         errors++; $display("FAIL bp_accept: got %b expected %b", {rsp_valid, busy}, 2'b00);
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_stuck_done();
      in1_a[3] = 32'd4; in2_a[3] = 32'd4;
      stuck = 1'b1; req = 4'b1000;
      tick();
      checks++;
      if (gnt !== 4'b1000) begin
         errors++; $display("FAIL stuck_grant: got %b expected %b", gnt, 4'b1000);
      end
`ifdef MACC_SCHED_TIMEOUT_EN
      repeat (14) tick();
      checks++;
      if ({rsp_valid, mac_ap_start} !== 2'b01) begin
         errors++; $display("FAIL tmo_run: got %b expected %b", {rsp_valid, mac_ap_start}, 2'b01);
      end
      tick();
      checks++;
      if ({rsp_valid, rsp_err, rsp_id, mac_ap_start} !== 5'b1_1_11_0) begin
         errors++; $display("FAIL tmo_rsp: got %b expected %b", {rsp_valid, rsp_err, rsp_id, mac_ap_start}, 5'b1_1_11_0);
      end
      checks++;
      if (rsp_data !== 32'd0) begin
         errors++; $display("FAIL tmo_data: got %h expected %h", rsp_data, 32'd0);
      end
      rsp_ready = 1'b1; req = 4'd0; stuck = 1'b0;
      tick();
      rsp_ready = 1'b0;
      repeat (4) tick();
      checks++;
      if ({busy, rsp_valid} !== 2'b00) begin
         errors++; $display("FAIL tmo_late_done: got %b expected %b", {busy, rsp_valid}, 2'b00);
      end
`else
      repeat (20) tick();
      checks++;
      if ({busy, mac_ap_start, rsp_valid, rsp_err} !== 4'b1100) begin
         errors++; $display("FAIL wait_run: got %b expected %b", {busy, mac_ap_start, rsp_valid, rsp_err}, 4'b1100);
      end
      stuck = 1'b0;
      for (int k = 0; k < 5 && !rsp_valid; k++) tick();
      checks++;
      if ({rsp_valid, rsp_id, rsp_err} !== 4'b1_11_0) begin
         errors++; $display("FAIL wait_rsp: got %b expected %b", {rsp_valid, rsp_id, rsp_err}, 4'b1_11_0);
      end
      checks++;
      if (rsp_data !== 32'd23) begin
         errors++; $display("FAIL wait_data: got %0d expected %0d", rsp_data, 32'd23);
      end
      rsp_ready = 1'b1; req = 4'd0;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL wait_accept: got %b expected %b", busy, 1'b0);
      end
`endif
   endtask

   task automatic test_reset_mid_run();
      in1_a[2] = 32'd3; in2_a[2] = 32'd3;
      req = 4'b0100;
      tick();
      checks++;
      if (gnt !== 4'b0100) begin
         errors++; $display("FAIL rst_run_grant: got %b expected %b", gnt, 4'b0100);
      end
      tick();
      #2 ap_rst_n = 1'b0;
      #1;
      checks++;
      if ({gnt, mac_ap_start, rsp_valid, busy, rsp_err, rsp_id} !== 10'd0) begin
         errors++; $display("FAIL rst_async: got %b expected %b", {gnt, mac_ap_start, rsp_valid, busy, rsp_err, rsp_id}, 10'd0);
      end
      checks++;
      if (rsp_data !== 32'd0) begin
         errors++; $display("FAIL rst_async_data: got %h expected %h", rsp_data, 32'd0);
      end
      tick();
      ap_rst_n = 1'b1;
      tick();
      checks++;
      if (gnt !== 4'b0100) begin
         errors++; $display("FAIL rst_regrant: got %b expected %b", gnt, 4'b0100);
      end
      repeat (4) tick();
      checks++;
      if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {1'b1, 2'd2, 1'b0, 32'd16}) begin
         errors++; $display("FAIL rst_rsp: got %b/%0d/%0d expected 1/2/16", rsp_valid, rsp_id, rsp_data);
      end
      rsp_ready = 1'b1; req = 4'd0;
      tick();
      rsp_ready = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL rst_accept: got %b expected %b", busy, 1'b0);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         in1_a[i] = 32'd0; in2_a[i] = 32'd0;
      end
      test_reset();
      test_single();
      test_done_ignored();
      test_round_robin();
      test_backpressure();
      test_stuck_done();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
